// File: rtl/dmem_pkg.sv
// Shared definitions for the clocked data memory: access size encodings,
// controller states and the alignment check used by the top level.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      INIT = 2'b00,
      IDLE = 2'b01,
      RESP = 2'b10
   } dmem_state_t;

   // Halves need an even address and words need a 4-byte aligned address;
   // bytes are always aligned and the reserved size is flagged elsewhere.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
      logic mis;
      mis = 1'b0;
      case (size)
         SZ_HALF: mis = addrLo[0];
         SZ_WORD: mis = |addrLo;
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory: picks and extends the
// load lanes out of a stored word, and builds byte enables plus the
// replicated store data for a lane-merged write.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [1:0]  addrLo_i,
   input  logic [31:0] rword_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] loadData_o,
   output logic [3:0]  byteEn_o,
   output logic [31:0] storeData_o
);

   logic [7:0]  loadByte;
   logic [15:0] loadHalf;

   // Select the addressed lanes, right-align them and extend to 32 bits; the
   // store side replicates the low data bytes so any enabled lane sees them.
   always_comb begin
      loadByte    = rword_i[8*addrLo_i +: 8];
      loadHalf    = addrLo_i[1] ? rword_i[31:16] : rword_i[15:0];
      loadData_o  = '0;
      byteEn_o    = '0;
      storeData_o = '0;
      case (size_i)
         SZ_BYTE: begin
            loadData_o  = signed_i ? {{24{loadByte[7]}}, loadByte} : {24'b0, loadByte};
            byteEn_o    = 4'b0001 << addrLo_i;
            storeData_o = {4{wdata_i[7:0]}};
         end
         SZ_HALF: begin
            loadData_o  = signed_i ? {{16{loadHalf[15]}}, loadHalf} : {16'b0, loadHalf};
            byteEn_o    = addrLo_i[1] ? 4'b1100 : 4'b0011;
            storeData_o = {2{wdata_i[15:0]}};
         end
         SZ_WORD: begin
            loadData_o  = rword_i;
            byteEn_o    = 4'b1111;
            storeData_o = wdata_i;
         end
         default: begin
            loadData_o  = '0;
            byteEn_o    = '0;
            storeData_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_sync.sv
// Clocked data memory for the MEM stage: request/response handshake with a
// one-cycle registered response, byte/half/word accesses with extension,
// alignment and range checking, and an optional zero-fill sweep after reset.
module dmem_sync
   import dmem_pkg::*;
#(
   parameter int DEPTH      = 32,
   parameter int ADDR_W     = 32,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [31:0]      mem_q [DEPTH];

   dmem_state_t      state_q;
   logic [IDX_W-1:0] sweepCnt_q;
   logic             ready_q;
   logic             rspValid_q;
   logic [31:0]      rspRdata_q;
   logic             rspErr_q;

   logic [IDX_W-1:0] wordIdx;
   logic             outOfRange;
   logic             reqErr;
   logic             accept;
   logic             sweepWe;
   logic             storeWe;
   logic [31:0]      loadData;
   logic [3:0]       byteEn;
   logic [31:0]      storeData;

   assign wordIdx    = req_addr[IDX_W+1:2];
   assign outOfRange = |(req_addr >> (IDX_W + 2));
   assign reqErr     = outOfRange || (req_size == SZ_RSVD) || isMisaligned(req_size, req_addr[1:0]);
   assign accept     = rst_n && (state_q == IDLE) && ready_q && req_valid;
   assign sweepWe    = rst_n && (state_q == INIT);
   assign storeWe    = accept && req_we && !reqErr;

   dmem_lane_align u_lane_align (
      .size_i      (req_size),
      .signed_i    (req_signed),
      .addrLo_i    (req_addr[1:0]),
      .rword_i     (mem_q[wordIdx]),
      .wdata_i     (req_wdata),
      .loadData_o  (loadData),
      .byteEn_o    (byteEn),
      .storeData_o (storeData)
   );

   // Array update: the zero-fill sweep owns the array while initialising,
   // otherwise an accepted error-free store merges its enabled lanes.
   always_ff @(posedge clk) begin
      if (sweepWe) begin
         mem_q[sweepCnt_q] <= '0;
      end else if (storeWe) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (byteEn[lane]) begin
               mem_q[wordIdx][8*lane +: 8] <= storeData[8*lane +: 8];
            end
         end
      end
   end

   // Controller: sweep, wait for a request, then emit the one-cycle response
   // captured from the pre-write array at the accepting edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= INIT_CLEAR ? INIT : IDLE;
         sweepCnt_q <= '0;
         ready_q    <= 1'b0;
         rspValid_q <= 1'b0;
         rspRdata_q <= '0;
         rspErr_q   <= 1'b0;
      end else begin
         case (state_q)
            INIT: begin
               ready_q <= 1'b0;
               if (sweepCnt_q == IDX_W'(DEPTH - 1)) begin
                  sweepCnt_q <= '0;
                  state_q    <= IDLE;
                  ready_q    <= 1'b1;
               end else begin
                  sweepCnt_q <= sweepCnt_q + 1'b1;
               end
            end
            IDLE: begin
               rspValid_q <= 1'b0;
               if (accept) begin
                  state_q    <= RESP;
                  ready_q    <= 1'b0;
                  rspValid_q <= 1'b1;
                  rspErr_q   <= reqErr;
                  rspRdata_q <= (reqErr || req_we) ? 32'h0 : loadData;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            RESP: begin
               state_q    <= IDLE;
               ready_q    <= 1'b1;
               rspValid_q <= 1'b0;
               rspRdata_q <= '0;
               rspErr_q   <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               ready_q    <= 1'b0;
               rspValid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rspValid_q;
   assign rsp_rdata = rspRdata_q;
   assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_dmem_sync.sv
// Directed bench for dmem_sync (DEPTH=32, INIT_CLEAR=1): reset and sweep
// timing, lane-merged stores, extended loads, error cases, reset during a
// response and mid-sweep, and back-to-back request throughput.
module tb_dmem_sync;
   import dmem_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int assertCount = 0;
   int failCount   = 0;

   dmem_sync #(.DEPTH(32), .ADDR_W(32), .INIT_CLEAR(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One counted comparison with a tagged report on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Issue one request from just after a clock edge, then check the response
   // pulse in the following cycle and its disappearance one cycle later.
   task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expRdata, input logic expErr);
      checkOutput({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wdata = 32'hA5A5_A5A5;
      checkOutput({tag, ".valid"}, {31'b0, rsp_valid}, 32'd1);
      checkOutput({tag, ".rdata"}, rsp_rdata, expRdata);
      checkOutput({tag, ".err"}, {31'b0, rsp_err}, {31'b0, expErr});
      @(posedge clk);
      #1;
      checkOutput({tag, ".pulse"}, {31'b0, rsp_valid}, 32'd0);
   endtask

   // Count rising edges until req_ready rises, bounded so a stuck sweep fails.
   task automatic waitReady(output int cycles);
      cycles = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         cycles++;
         if (req_ready) break;
      end
   endtask

   initial begin
      int cycles;
      int accepts;
      int pulses;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = SZ_WORD;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset.ready", {31'b0, req_ready}, 32'd0);
      checkOutput("reset.valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("reset.rdata", rsp_rdata, 32'd0);
      checkOutput("reset.err", {31'b0, rsp_err}, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      waitReady(cycles);
      checkOutput("sweep.cycles", cycles, 32'd32);

      applyStimulus("ld0", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 32'h0000_0000, 1'b0);
      applyStimulus("ld7c", 1'b0, SZ_WORD, 1'b0, 32'h7C, 32'h0, 32'h0000_0000, 1'b0);

      applyStimulus("stw", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
      applyStimulus("ldw", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

      applyStimulus("stb", 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hFFFF_FF80, 32'h0, 1'b0);
      applyStimulus("ldbs", 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'hFFFF_FF80, 1'b0);
      applyStimulus("ldbu", 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 32'h0000_0080, 1'b0);
      applyStimulus("ldw2", 1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, 32'hDEAD_80EF, 1'b0);
      applyStimulus("ldb0s", 1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0);

      applyStimulus("ldhs", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0);
      applyStimulus("ldhu", 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 32'h0000_80EF, 1'b0);
      applyStimulus("sth", 1'b1, SZ_HALF, 1'b0, 32'h12, 32'hABCD_1234, 32'h0, 1'b0);
      applyStimulus("ldw3", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h1234_80EF, 1'b0);

      applyStimulus("errw", 1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
      applyStimulus("errh", 1'b1, SZ_HALF, 1'b0, 32'h13, 32'h0000_FFFF, 32'h0, 1'b1);
      applyStimulus("errsz", 1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
      applyStimulus("errrng", 1'b1, SZ_WORD, 1'b0, 32'h80, 32'h1111_2222, 32'h0, 1'b1);
      applyStimulus("keep10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h1234_80EF, 1'b0);
      applyStimulus("keep00", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 32'h0000_0000, 1'b0);

      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = SZ_WORD;
      req_addr  = 32'h10;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checkOutput("rstresp.valid", {31'b0, rsp_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rstresp.sync", {31'b0, rsp_valid}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("rstresp.drop", {31'b0, rsp_valid}, 32'd0);
      checkOutput("rstresp.ready", {31'b0, req_ready}, 32'd0);
      rst_n = 1'b1;

      repeat (10) @(posedge clk);
      #1;
      checkOutput("midinit.ready", {31'b0, req_ready}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      waitReady(cycles);
      checkOutput("resweep.cycles", cycles, 32'd32);
      applyStimulus("cleared", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0000_0000, 1'b0);

      accepts    = 0;
      pulses     = 0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_size   = SZ_WORD;
      req_addr   = 32'h00;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput($sformatf("b2b.ready%0d", i), {31'b0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         checkOutput($sformatf("b2b.valid%0d", i), {31'b0, rsp_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
         if (req_ready && req_valid) accepts++;
         if (rsp_valid) pulses++;
      end
      req_valid = 1'b0;
      checkOutput("b2b.accepts", accepts, 32'd4);
      checkOutput("b2b.pulses", pulses, 32'd4);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/dmem_sync.md
Name: dmem_sync

Overview:
Clocked, parametrised data memory for the processor datapath. It is the successor to the combinational word-only data memory. It adds a request/response handshake, registered read with fixed latency, byte/half/word accesses with sign or zero extension, alignment and range checking, and an optional zero-fill sweep after reset. It sits in the MEM stage between the ALU address output and the write-back mux.

Parameters:
DEPTH, 32, number of 32-bit words; power of two, at least 4
ADDR_W, 32, width of the byte address input; must satisfy ADDR_W >= clog2(DEPTH)+2
INIT_CLEAR, 1, 1 = zero all words after reset before accepting requests; 0 = contents undefined, ready immediately

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (the low bytes are used)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result, extended; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid: misaligned, out of range, or reserved size

Behaviour:
- Everything is on the rising edge of clk. rst_n is sampled synchronously, so an asynchronous rst_n edge has no effect until the next clock edge.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=INIT (INIT_CLEAR=1) or IDLE (INIT_CLEAR=0), sweep counter=0. The memory array is not reset.
- States:
  - INIT: writes 0 to word[cnt] and increments cnt each cycle; req_ready=0. After writing word DEPTH-1, goes to IDLE. The sweep takes exactly DEPTH cycles.
  - IDLE: req_ready=1. A request is accepted when req_valid && req_ready, then the state goes to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then the state returns to IDLE.
  - Sustained throughput is therefore one request per 2 cycles.
- Latency: a request accepted at edge N has rsp_valid high during cycle N+1, i.e. registered at edge N.
- Word index is req_addr[clog2(DEPTH)+1:2]. The access is out of range if any req_addr bit above clog2(DEPTH)+1 is 1.
- Error conditions:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - size=11
  - out of range
  - On any error: no memory write, rsp_err=1, rsp_rdata=0.
- Store lane merge; unwritten bytes keep their value:
  - byte: writes req_wdata[7:0] into lane addr[1:0].
  - half: writes req_wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - word: writes all 4 lanes.
  - Successful store: rsp_rdata=0, rsp_err=0.
- Load: selects the lane(s) the same way as a store, shifts them to bit 0, then extends per req_signed. For a word load req_signed is ignored.
- Lanes are little-endian: lane 0 = bits 7:0.
- Request inputs are sampled only at the accepting edge. Changes in other cycles are ignored.
- Reset mid-operation:
  - Reset during INIT restarts the sweep from word 0.
  - Reset during RESP drops the pending response (rsp_valid=0 next cycle). A store already accepted has already been written at its accepting edge and is not undone.
- Reads are performed at the accepting edge against the pre-write array. A load can never overlap a store because only one request is in flight.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD
  - state enum INIT, IDLE, RESP
  - a function computing the misalignment flag from size and addr[1:0]
- One natural sub-module, dmem_lane_align. It is purely combinational: load-side lane select plus sign/zero extend, and store-side byte-enable/lane-shift generation. The top keeps the FSM, the array and the response registers.

Test Plan:
- INIT_CLEAR=1, DEPTH=32: release rst_n -> req_ready=0 for exactly 32 cycles, then 1. Word loads at 0x00, 0x7C -> rdata=0x00000000, err=0.
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> 0xDEADBEEF. rsp_valid is high for exactly one cycle, on the cycle after each accept.
- Byte store 0x80 @0x11, then signed byte load @0x11 -> 0xFFFFFF80; unsigned -> 0x00000080. Word load @0x10 -> 0xDEAD80EF.
- Signed half load @0x12 after step 2 -> 0xFFFFDEAD. Half store 0x1234 @0x12, then word load -> 0x123480EF.
- Errors, each giving err=1, rdata=0, memory unchanged:
  - word load @0x11
  - half store @0x13
  - size=11
  - store @0x80 with DEPTH=32
- rst_n low for one cycle during RESP -> no rsp_valid. Reset asserted mid-INIT at cnt=10 -> a fresh 32-cycle sweep follows. Back-to-back req_valid held high -> accepts exactly every 2nd cycle.
